// File: rtl/io_hub_pkg.sv
// rtl/io_hub_pkg.sv - register map, bit positions and filter states for mmio_io_hub
package io_hub_pkg;

  localparam logic [11:0] ADDR_LED      = 12'h000;
  localparam logic [11:0] ADDR_DIGIT_EN = 12'h001;
  localparam logic [11:0] ADDR_KEY      = 12'h002;
  localparam logic [11:0] ADDR_STATUS   = 12'h003;
  localparam logic [11:0] ADDR_CTRL     = 12'h004;
  localparam logic [11:0] ADDR_HEX_BASE = 12'h010;

  localparam int KEY_VALID_BIT    = 8;
  localparam int STATUS_OVF_BIT   = 16;
  localparam int STATUS_EMPTY_BIT = 17;
  localparam int STATUS_FULL_BIT  = 18;
  localparam int CTRL_IRQ_EN_BIT  = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

  localparam logic [7:0] BREAK_CODE = 8'hF0;

  typedef enum logic {
    FILT_PASS = 1'b0,
    FILT_SKIP = 1'b1
  } filt_state_t;

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - 8-bit synchronous scancode FIFO with push, pop and flush
module key_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_io_hub.sv
// rtl/mmio_io_hub.sv - memory-mapped LED, hex-digit and PS/2 scancode hub
module mmio_io_hub
  import io_hub_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int KEY_FIFO_DEPTH = 8,
  parameter int LED_WIDTH      = 8,
  parameter int FILTER_BREAK   = 0
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [11:0]             addr,
  input  logic [31:0]             wdata,
  input  logic                    wren,
  input  logic                    rden,
  output logic [31:0]             rdata,
  input  logic                    key_valid,
  input  logic [7:0]              key_code,
  output logic [4*NUM_DIGITS-1:0] hex_digits,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [LED_WIDTH-1:0]    leds,
  output logic                    irq
);
  localparam int CW = $clog2(KEY_FIFO_DEPTH) + 1;

  filt_state_t   filt_state;
  logic          irq_en;
  logic          overflow;
  logic          push_req;
  logic          pop;
  logic          flush;
  logic          ovf_set;
  logic          ovf_clr;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   rd_next;

  assign pop     = rden && (addr == ADDR_KEY) && !fifo_empty;
  assign flush   = wren && (addr == ADDR_CTRL) && wdata[CTRL_FLUSH_BIT];
  assign ovf_set = push_req && fifo_full && !pop && !flush;
  assign ovf_clr = wren && (addr == ADDR_STATUS) && wdata[STATUS_OVF_BIT];
  assign irq     = irq_en && !fifo_empty;

  always_comb begin
    push_req = key_valid;
    if (FILTER_BREAK != 0)
      push_req = key_valid && (filt_state == FILT_PASS) && (key_code != BREAK_CODE);
  end

  key_fifo #(.DEPTH(KEY_FIFO_DEPTH)) u_key_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push_req),
    .pop    (pop),
    .flush  (flush),
    .din    (key_code),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Break-code filter: 0xF0 and the byte after it never reach the FIFO.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      filt_state <= FILT_PASS;
    end else if (flush || FILTER_BREAK == 0) begin
      filt_state <= FILT_PASS;
    end else if (key_valid) begin
      case (filt_state)
        FILT_PASS: if (key_code == BREAK_CODE) filt_state <= FILT_SKIP;
        FILT_SKIP: filt_state <= FILT_PASS;
        default:   filt_state <= FILT_PASS;
      endcase
    end
  end

  always_comb begin
    rd_next = '0;
    case (addr)
      ADDR_LED:      rd_next[LED_WIDTH-1:0] = leds;
      ADDR_DIGIT_EN: rd_next[NUM_DIGITS-1:0] = digit_en;
      ADDR_KEY: begin
        rd_next[7:0]          = fifo_empty ? 8'h00 : fifo_dout;
        rd_next[KEY_VALID_BIT] = !fifo_empty;
      end
      ADDR_STATUS: begin
        rd_next[CW-1:0]           = fifo_count;
        rd_next[STATUS_OVF_BIT]   = overflow;
        rd_next[STATUS_EMPTY_BIT] = fifo_empty;
        rd_next[STATUS_FULL_BIT]  = fifo_full;
      end
      ADDR_CTRL:     rd_next[CTRL_IRQ_EN_BIT] = irq_en;
      default:       rd_next = '0;
    endcase
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (addr == ADDR_HEX_BASE + 12'(d / 8))
        rd_next[4*(d%8) +: 4] = hex_digits[4*d +: 4];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdata      <= '0;
      leds       <= '0;
      digit_en   <= '1;
      hex_digits <= '0;
      irq_en     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (rden) rdata <= rd_next;
      // A drop in the same cycle as a clear keeps the flag set so the loss is seen.
      overflow <= (overflow && !ovf_clr) || ovf_set;
      if (wren) begin
        case (addr)
          ADDR_LED:      leds     <= wdata[LED_WIDTH-1:0];
          ADDR_DIGIT_EN: digit_en <= wdata[NUM_DIGITS-1:0];
          ADDR_CTRL:     irq_en   <= wdata[CTRL_IRQ_EN_BIT];
          default:       ;
        endcase
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (addr == ADDR_HEX_BASE + 12'(d / 8))
            hex_digits[4*d +: 4] <= wdata[4*(d%8) +: 4];
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// tb/tb_mmio_io_hub.sv - scoreboard bench for mmio_io_hub with a queue-based reference model
module tb_mmio_io_hub;

  logic        clock = 1'b0;
  logic        resetn;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        wren;
  logic        rden;
  logic [31:0] rdata;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [31:0] hex_digits;
  logic [7:0]  digit_en;
  logic [7:0]  leds;
  logic        irq;

  always #5 clock = ~clock;

  mmio_io_hub #(
    .NUM_DIGITS(8), .KEY_FIFO_DEPTH(8), .LED_WIDTH(8), .FILTER_BREAK(1)
  ) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata), .wren(wren),
    .rden(rden), .rdata(rdata), .key_valid(key_valid), .key_code(key_code),
    .hex_digits(hex_digits), .digit_en(digit_en), .leds(leds), .irq(irq)
  );

  // Reference model state
  logic [7:0]  m_fifo[$];
  logic [7:0]  m_led;
  logic [7:0]  m_den;
  logic [31:0] m_hex;
  bit          m_ovf;
  bit          m_irq_en;
  bit          m_skip;
  logic [31:0] exp_q[$];

  int passed = 0;
  int total  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_led = 8'h00; m_den = 8'hFF; m_hex = 32'h0;
    m_ovf = 0; m_irq_en = 0; m_skip = 0;
  endtask

  function automatic logic [31:0] model_read(logic [11:0] a);
    case (a)
      12'h000: return {24'h0, m_led};
      12'h001: return {24'h0, m_den};
      12'h002: return (m_fifo.size() > 0) ? {23'h0, 1'b1, m_fifo[0]} : 32'h0;
      12'h003: return {13'h0, (m_fifo.size() == 8), (m_fifo.size() == 0), m_ovf,
                       7'h0, 9'(m_fifo.size())};
      12'h004: return {31'h0, m_irq_en};
      12'h010: return m_hex;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("leds", {24'h0, leds}, {24'h0, m_led});
    chk("digit_en", {24'h0, digit_en}, {24'h0, m_den});
    chk("hex_digits", hex_digits, m_hex);
    chk("irq", {31'h0, irq}, {31'h0, m_irq_en && (m_fifo.size() > 0)});
  endtask

  // One bus/key cycle: check the state left by the previous edge, drive, advance the model.
  task automatic cycle(bit w, bit r, logic [11:0] a, logic [31:0] wd, bit kv, logic [7:0] kc);
    bit       accept, pop_now, flush_now, was_full;
    @(negedge clock);
    check_outputs();
    wren = w; rden = r; addr = a; wdata = wd; key_valid = kv; key_code = kc;
    if (r) exp_q.push_back(model_read(a));
    flush_now = w && a == 12'h004 && wd[1];
    pop_now   = r && a == 12'h002 && m_fifo.size() > 0;
    was_full  = m_fifo.size() == 8;
    accept = 0;
    if (kv) begin
      if (m_skip) m_skip = 0;
      else if (kc == 8'hF0) m_skip = 1;
      else accept = 1;
    end
    if (flush_now) begin
      m_fifo.delete();
      m_skip = 0;
    end else begin
      if (pop_now) void'(m_fifo.pop_front());
      if (accept) begin
        if (!was_full || pop_now) m_fifo.push_back(kc);
        else m_ovf = 1;
      end
    end
    if (w && a == 12'h003 && wd[16] && !(accept && was_full && !pop_now && !flush_now))
      m_ovf = 0;
    if (w) begin
      case (a)
        12'h000: m_led = wd[7:0];
        12'h001: m_den = wd[7:0];
        12'h004: m_irq_en = wd[0];
        12'h010: m_hex = wd;
        default: ;
      endcase
    end
  endtask

  task automatic idle();
    cycle(0, 0, 12'h0, 32'h0, 0, 8'h0);
  endtask

  // Monitor: every read strobe seen at an edge yields one rdata comparison.
  bit rd_seen;
  always begin
    @(posedge clock);
    rd_seen = rden && resetn;
    #2;
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL rdata_unexpected: got %h expected no read", rdata);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  logic [11:0] addr_pool [8] = '{12'h000, 12'h001, 12'h002, 12'h003,
                                 12'h004, 12'h010, 12'h011, 12'h7FF};

  initial begin
    resetn = 0; wren = 0; rden = 0; addr = 0; wdata = 0; key_valid = 0; key_code = 0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_rdata", rdata, 32'h0);
    resetn = 1;

    cycle(0, 1, 12'h003, 0, 0, 0);
    idle();

    cycle(1, 0, 12'h010, 32'h12345678, 0, 0);
    cycle(1, 0, 12'h001, 32'h0000000F, 0, 0);
    cycle(0, 1, 12'h010, 0, 0, 0);
    cycle(0, 1, 12'h001, 0, 0, 0);
    cycle(1, 1, 12'h000, 32'hA5, 0, 0);
    cycle(0, 1, 12'h000, 0, 0, 0);

    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 1, 8'(8'h1C + i));
    cycle(0, 1, 12'h003, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 12'h002, 0, 0, 0);
    cycle(1, 0, 12'h003, 32'h00010000, 0, 0);
    cycle(0, 1, 12'h003, 0, 0, 0);

    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 8'(8'h30 + i));
    cycle(0, 1, 12'h002, 0, 1, 8'h38);
    cycle(0, 1, 12'h003, 0, 0, 0);
    cycle(1, 0, 12'h004, 32'h2, 0, 0);

    cycle(0, 0, 0, 0, 1, 8'h1C);
    cycle(0, 0, 0, 0, 1, 8'hF0);
    cycle(0, 0, 0, 0, 1, 8'h1C);
    cycle(0, 0, 0, 0, 1, 8'h32);
    for (int i = 0; i < 3; i++) cycle(0, 1, 12'h002, 0, 0, 0);

    cycle(1, 0, 12'h004, 32'h1, 0, 0);
    cycle(0, 0, 0, 0, 1, 8'h45);
    idle();
    cycle(1, 0, 12'h004, 32'h3, 1, 8'h46);
    cycle(0, 1, 12'h003, 0, 0, 0);
    idle();

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            addr_pool[$urandom_range(0, 7)], $urandom,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 4) == 0) ? 8'hF0 : 8'($urandom));
    end
    idle();

    cycle(1, 0, 12'h000, 32'h5A, 1, 8'h11);
    cycle(1, 0, 12'h004, 32'h1, 1, 8'h22);
    idle();
    @(negedge clock);
    resetn = 0;
    model_reset();
    #1;
    check_outputs();
    chk("midreset_rdata", rdata, 32'h0);
    @(negedge clock);
    resetn = 1;
    cycle(0, 1, 12'h003, 0, 0, 0);
    idle();
    idle();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
